// File: rtl/serial_word_receiver_pkg.sv
// Shared types and constants for the serial word receiver and its shift core.
package serial_word_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_GAP  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  // fold is the XOR of every data bit and the parity bit.
  function automatic logic parity_ok(input logic fold, input int mode);
    return (mode == PARITY_ODD) ? fold : !fold;
  endfunction

endpackage

// File: rtl/serial_word_receiver_deser_shift_core.sv
// Deserialising shift register with direction select, shift enable and synchronous clear.
module deser_shift_core
  import serial_word_receiver_pkg::*;
#(
  parameter int    DATA_WIDTH      = 8,
  parameter string SHIFT_DIRECTION = DIR_LEFT
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  i_shift_en,
  input  logic                  i_clear,
  input  logic                  i_bit,
  output logic [DATA_WIDTH-1:0] o_next_word
);

  localparam bit SHIFT_LEFT = (SHIFT_DIRECTION != DIR_RIGHT);

  logic [DATA_WIDTH-1:0] r_sh;

  // The value the register takes at the next edge, so the top can latch a word
  // on the same edge that captures its final data bit.
  always_comb begin
    o_next_word = r_sh;
    if (i_clear)
      o_next_word = '0;
    else if (i_shift_en)
      o_next_word = SHIFT_LEFT ? {r_sh[DATA_WIDTH-2:0], i_bit}
                               : {i_bit, r_sh[DATA_WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)
      r_sh <= '0;
    else
      r_sh <= o_next_word;
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver: FSM, bit counter and parity check around the shift core.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int    DATA_WIDTH      = 8,
  parameter string SHIFT_DIRECTION = DIR_LEFT,
  parameter int    PARITY_MODE     = PARITY_NONE
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  enable,
  input  logic                  serial_in,
  input  logic                  frame,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic                  parity_error,
  output logic                  busy,
  output logic [5:0]            bit_count
);

  localparam bit         HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam int         FRAME_LEN  = DATA_WIDTH + (HAS_PARITY ? 1 : 0);
  localparam logic [5:0] LAST_IDX   = 6'(FRAME_LEN - 1);
  localparam logic [5:0] DATA_BITS  = 6'(DATA_WIDTH);

  state_t                r_state;
  logic [5:0]            r_bit_count;
  logic                  r_par_acc;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_frame_error;
  logic                  r_parity_error;

  state_t                w_state_next;
  logic [5:0]            w_cnt_next;
  logic                  w_par_next;
  logic                  w_par_fold;
  logic                  w_shift_en;
  logic                  w_clear;
  logic                  w_valid;
  logic                  w_ferr;
  logic                  w_perr;
  logic [DATA_WIDTH-1:0] w_next_word;

  deser_shift_core #(
    .DATA_WIDTH      (DATA_WIDTH),
    .SHIFT_DIRECTION (SHIFT_DIRECTION)
  ) u_shift (
    .clock       (clock),
    .aclr        (aclr),
    .i_shift_en  (w_shift_en),
    .i_clear     (w_clear),
    .i_bit       (serial_in),
    .o_next_word (w_next_word)
  );

  assign w_par_fold = r_par_acc ^ serial_in;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_bit_count;
    w_par_next   = r_par_acc;
    w_shift_en   = 1'b0;
    w_clear      = 1'b0;
    w_valid      = 1'b0;
    w_ferr       = 1'b0;
    w_perr       = 1'b0;
    if (enable) begin
      unique case (r_state)
        ST_IDLE: begin
          if (frame) begin
            w_shift_en   = 1'b1;
            w_par_next   = serial_in;
            w_cnt_next   = 6'd1;
            w_state_next = ST_RECV;
          end else begin
            w_clear = 1'b1;
          end
        end
        ST_RECV: begin
          if (frame) begin
            // The parity bit, if any, is counted but never shifted in.
            w_shift_en = (r_bit_count < DATA_BITS);
            w_par_next = w_par_fold;
            if (r_bit_count == LAST_IDX) begin
              w_cnt_next   = 6'd0;
              w_state_next = ST_GAP;
              if (!HAS_PARITY || parity_ok(w_par_fold, PARITY_MODE))
                w_valid = 1'b1;
              else
                w_perr = 1'b1;
            end else begin
              w_cnt_next = r_bit_count + 6'd1;
            end
          end else begin
            w_ferr       = 1'b1;
            w_clear      = 1'b1;
            w_cnt_next   = 6'd0;
            w_state_next = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (frame) begin
            w_ferr       = 1'b1;
            w_state_next = ST_ERR;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_ERR: begin
          if (!frame)
            w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Pulses reload every clock, so they last one cycle even if enable drops.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_state        <= ST_IDLE;
      r_bit_count    <= 6'd0;
      r_par_acc      <= 1'b0;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_frame_error  <= 1'b0;
      r_parity_error <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_bit_count    <= w_cnt_next;
      r_par_acc      <= w_par_next;
      r_data_valid   <= w_valid;
      r_frame_error  <= w_ferr;
      r_parity_error <= w_perr;
      if (w_valid)
        r_data_out <= w_next_word;
    end
  end

  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign frame_error  = r_frame_error;
  assign parity_error = r_parity_error;
  assign busy         = (r_state == ST_RECV);
  assign bit_count    = r_bit_count;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench: four receiver configurations against a frame-level reference model.
module tb_serial_word_receiver;

  logic       clock = 1'b0;
  logic       aclr  = 1'b0;
  logic       en  [4];
  logic       ser [4];
  logic       frm [4];
  logic [7:0] dout [4];
  logic       dv   [4];
  logic       fe   [4];
  logic       pe   [4];
  logic       bz   [4];
  logic [5:0] bc   [4];

  // Reference configuration of each instance and the model's last accepted word.
  int         fl   [4] = '{8, 8, 9, 9};
  int         mode [4] = '{0, 0, 1, 2};
  bit         left [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp_dout [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  serial_word_receiver #(.DATA_WIDTH(8), .SHIFT_DIRECTION("LEFT"), .PARITY_MODE(0)) u_d0 (
    .clock(clock), .aclr(aclr), .enable(en[0]), .serial_in(ser[0]), .frame(frm[0]),
    .data_out(dout[0]), .data_valid(dv[0]), .frame_error(fe[0]), .parity_error(pe[0]),
    .busy(bz[0]), .bit_count(bc[0]));
  serial_word_receiver #(.DATA_WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .PARITY_MODE(0)) u_d1 (
    .clock(clock), .aclr(aclr), .enable(en[1]), .serial_in(ser[1]), .frame(frm[1]),
    .data_out(dout[1]), .data_valid(dv[1]), .frame_error(fe[1]), .parity_error(pe[1]),
    .busy(bz[1]), .bit_count(bc[1]));
  serial_word_receiver #(.DATA_WIDTH(8), .SHIFT_DIRECTION("LEFT"), .PARITY_MODE(1)) u_d2 (
    .clock(clock), .aclr(aclr), .enable(en[2]), .serial_in(ser[2]), .frame(frm[2]),
    .data_out(dout[2]), .data_valid(dv[2]), .frame_error(fe[2]), .parity_error(pe[2]),
    .busy(bz[2]), .bit_count(bc[2]));
  serial_word_receiver #(.DATA_WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .PARITY_MODE(2)) u_d3 (
    .clock(clock), .aclr(aclr), .enable(en[3]), .serial_in(ser[3]), .frame(frm[3]),
    .data_out(dout[3]), .data_valid(dv[3]), .frame_error(fe[3]), .parity_error(pe[3]),
    .busy(bz[3]), .bit_count(bc[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_dut(input int d, input string tag, input logic ev, input logic ef,
                           input logic ep, input logic eb, input logic [5:0] ebc);
    chk({tag, " data_out"},     32'(dout[d]), 32'(exp_dout[d]));
    chk({tag, " data_valid"},   32'(dv[d]),   32'(ev));
    chk({tag, " frame_error"},  32'(fe[d]),   32'(ef));
    chk({tag, " parity_error"}, 32'(pe[d]),   32'(ep));
    chk({tag, " busy"},         32'(bz[d]),   32'(eb));
    chk({tag, " bit_count"},    32'(bc[d]),   32'(ebc));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Transmission order for a word sent MSB first: element i is word bit 7-i.
  function automatic logic [63:0] msb_first(input logic [7:0] w);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = w[7 - i];
    return b;
  endfunction

  function automatic logic [63:0] lsb_first(input logic [7:0] w);
    return {56'd0, w};
  endfunction

  // Drive n frame-high cycles of bits[0..n-1], then one idle cycle; tog inserts a
  // disabled cycle with junk inputs before every bit.
  task automatic send(input int d, input logic [63:0] bits, input int n,
                      input bit tog, input string name);
    logic [7:0] word;
    int         ones;
    bit         ok;
    logic       ev, ef, ep, eb;
    logic [5:0] ebc;
    eb  = 1'b0;
    ebc = 6'd0;
    for (int i = 0; i < n; i++) begin
      if (tog) begin
        en[d] = 1'b0; frm[d] = 1'($urandom); ser[d] = 1'($urandom);
        tick();
        check_dut(d, $sformatf("%s hold%0d", name, i), 1'b0, 1'b0, 1'b0, eb, ebc);
      end
      en[d] = 1'b1; frm[d] = 1'b1; ser[d] = bits[i];
      tick();
      ev = 1'b0; ef = 1'b0; ep = 1'b0;
      if (i == fl[d] - 1) begin
        word = 8'd0;
        ones = 0;
        for (int j = 0; j < 8; j++) begin
          if (left[d]) word = (word << 1) | 8'(bits[j]);
          else         word = word | (8'(bits[j]) << j);
          ones += int'(bits[j]);
        end
        if (mode[d] != 0) ones += int'(bits[8]);
        ok = (mode[d] == 0) || ((ones % 2) == ((mode[d] == 2) ? 1 : 0));
        if (ok) begin
          ev = 1'b1;
          exp_dout[d] = word;
        end else begin
          ep = 1'b1;
        end
      end
      if (i == fl[d]) ef = 1'b1;
      eb  = (i < fl[d] - 1);
      ebc = eb ? 6'(i + 1) : 6'd0;
      check_dut(d, $sformatf("%s bit%0d", name, i), ev, ef, ep, eb, ebc);
    end
    en[d] = 1'b1; frm[d] = 1'b0; ser[d] = 1'b0;
    tick();
    check_dut(d, {name, " end"}, 1'b0, (n > 0 && n < fl[d]), 1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    logic [63:0] b;
    int          d, n, r;
    for (int k = 0; k < 4; k++) begin
      en[k] = 1'b1; ser[k] = 1'b0; frm[k] = 1'b0; exp_dout[k] = 8'd0;
    end

    #2 aclr = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) check_dut(k, $sformatf("reset d%0d", k), 0, 0, 0, 0, 6'd0);
    aclr = 1'b0;
    tick();

    send(0, msb_first(8'hA5), 8, 1'b0, "left_a5");
    chk("left_a5 literal", 32'(dout[0]), 32'h0000_00A5);

    send(1, lsb_first(8'hA5), 8, 1'b0, "right_a5");
    chk("right_a5 literal", 32'(dout[1]), 32'h0000_00A5);
    send(1, lsb_first(8'hA5), 8, 1'b1, "right_a5_toggle");
    chk("right_a5_toggle literal", 32'(dout[1]), 32'h0000_00A5);

    b = msb_first(8'hA5); b[8] = 1'b0;
    send(2, b, 9, 1'b0, "even_good");
    chk("even_good literal", 32'(dout[2]), 32'h0000_00A5);
    b[8] = 1'b1;
    send(2, b, 9, 1'b0, "even_bad");
    chk("even_bad literal", 32'(dout[2]), 32'h0000_00A5);

    send(0, msb_first(8'hFF), 5, 1'b0, "short");
    chk("short literal", 32'(dout[0]), 32'h0000_00A5);
    send(0, msb_first(8'h3C), 8, 1'b0, "after_short");
    chk("after_short literal", 32'(dout[0]), 32'h0000_003C);

    b = msb_first(8'h5A); b[8] = 1'b1;
    send(0, b, 9, 1'b0, "overrun");
    chk("overrun literal", 32'(dout[0]), 32'h0000_005A);
    send(0, msb_first(8'h81), 8, 1'b0, "after_overrun");
    chk("after_overrun literal", 32'(dout[0]), 32'h0000_0081);

    b = msb_first(8'hC3);
    for (int i = 0; i < 3; i++) begin
      frm[0] = 1'b1; ser[0] = b[i];
      tick();
    end
    #2 aclr = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) exp_dout[k] = 8'd0;
    for (int k = 0; k < 4; k++) check_dut(k, $sformatf("aclr d%0d", k), 0, 0, 0, 0, 6'd0);
    frm[0] = 1'b0;
    tick();
    aclr = 1'b0;
    send(0, msb_first(8'h3C), 8, 1'b0, "after_aclr");
    chk("after_aclr literal", 32'(dout[0]), 32'h0000_003C);

    for (int k = 0; k < 60; k++) begin
      d = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r < 6)      n = fl[d];
      else if (r < 8) n = int'($urandom_range(1, fl[d] - 1));
      else            n = int'($urandom_range(fl[d] + 1, fl[d] + 3));
      b = {$urandom, $urandom};
      send(d, b, n, 1'($urandom), $sformatf("rand%0d d%0d n%0d", k, d, n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
